tick_scheduler: RTL and testbench

- Programmable prescaler plus round-robin arbiter for the calculator's slow-tick resource.
- Divides CLOCK by a runtime-loadable value and emits a one-cycle TICK per period.
- Grants each TICK to exactly one of NREQ requesters (display scan, keypad debounce, ALU step, ...) in fair rotation.
- Replaces fixed 2**N division where consumers need a shared, reconfigurable tick.

---
 rtl/tick_scheduler.sv | 134 +++++++++++++
 tb/tb_tick_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: runtime-loadable prescaler emitting a one-cycle TICK per period,
// with a round-robin arbiter handing each TICK to one of NREQ requesters.
module tick_scheduler #(
    parameter int             W           = 23,
    parameter int             NREQ        = 4,
    parameter logic [W-1:0]   DEFAULT_DIV = {{(W-1){1'b1}}, 1'b0}
) (
    input  logic                     CLOCK,
    input  logic                     CLEAR,
    input  logic                     ENABLE,
    input  logic                     LOAD,
    input  logic [W-1:0]             DIV_IN,
    input  logic [NREQ-1:0]          REQ,
    output logic                     TICK,
    output logic [NREQ-1:0]          GNT,
    output logic [$clog2(NREQ)-1:0]  GNT_ID,
    output logic                     BUSY,
    output logic [W-1:0]             COUNT
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      count_q, count_d;
    logic [W-1:0]      div_q, div_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              tick_q, tick_d;
    logic              busy_q, busy_d;

    logic              hit;
    logic [IW-1:0]     win;

    // Rotating search: first requester at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        int idx;
        hit = 1'b0;
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!hit && REQ[idx]) begin
                hit = 1'b1;
                win = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        div_d    = div_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        gnt_d    = '0;
        tick_d   = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    div_d   = DIV_IN;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RELOAD;
                end else if (ENABLE) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (LOAD) begin
                    div_d   = DIV_IN;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RELOAD;
                end else if (!ENABLE) begin
                    state_d = IDLE;
                end else if (count_q == div_q) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    if (hit) begin
                        gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
                        gnt_id_d = win;
                        ptr_d    = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            RELOAD: begin
                // LOAD is deliberately not looked at here.
                state_d = ENABLE ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q  <= IDLE;
            count_q  <= '0;
            div_q    <= DEFAULT_DIV;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            gnt_q    <= '0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            div_q    <= div_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            gnt_q    <= gnt_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
        end
    end

    assign TICK   = tick_q;
    assign GNT    = gnt_q;
    assign GNT_ID = gnt_id_q;
    assign BUSY   = busy_q;
    assign COUNT  = count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: abstract reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and grants.
module tb_tick_scheduler;

    localparam int W    = 4;
    localparam int NREQ = 4;

    logic            CLOCK = 1'b0;
    logic            CLEAR;
    logic            ENABLE;
    logic            LOAD;
    logic [W-1:0]    DIV_IN;
    logic [NREQ-1:0] REQ;
    logic            TICK;
    logic [NREQ-1:0] GNT;
    logic [1:0]      GNT_ID;
    logic            BUSY;
    logic [W-1:0]    COUNT;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    tick_scheduler #(.W(W), .NREQ(NREQ)) dut (
        .CLOCK(CLOCK), .CLEAR(CLEAR), .ENABLE(ENABLE), .LOAD(LOAD),
        .DIV_IN(DIV_IN), .REQ(REQ), .TICK(TICK), .GNT(GNT),
        .GNT_ID(GNT_ID), .BUSY(BUSY), .COUNT(COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: updates on the falling edge, compared on the rising edge.
    int m_count, m_div, m_ptr, m_id, m_gnt;
    bit m_tick, m_busy, m_run, was_reload;

    always @(negedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            m_count = 0; m_div = (1 << W) - 2; m_ptr = 0; m_id = 0;
            m_gnt = 0; m_tick = 0; m_busy = 0; m_run = 0;
        end else begin
            was_reload = m_busy;
            m_tick = 0; m_gnt = 0; m_busy = 0;
            if (was_reload) m_run = ENABLE;
            else if (LOAD) begin
                m_div = DIV_IN; m_count = 0; m_busy = 1;
            end
            else if (!ENABLE) m_run = 0;
            else if (!m_run) m_run = 1;
            else if (m_count == m_div) begin
                m_count = 0; m_tick = 1;
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (m_gnt == 0 && REQ[j]) begin
                        m_gnt = 1 << j; m_id = j; m_ptr = (j + 1) % NREQ;
                    end
                end
            end
            else m_count = m_count + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLOCK) begin
        if (chk_en && CLEAR) begin
            check("model COUNT", int'(COUNT), m_count);
            check("model TICK", int'(TICK), int'(m_tick));
            check("model GNT", int'(GNT), m_gnt);
            check("model GNT_ID", int'(GNT_ID), m_id);
            check("model BUSY", int'(BUSY), int'(m_busy));
        end
    end

    // Counts rising edges until TICK is seen; returns -1 on timeout.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(posedge CLOCK);
            n++;
        end while (!TICK && n < budget);
        if (!TICK) n = -1;
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        do begin
            @(posedge CLOCK);
            n++;
        end while (int'(COUNT) != target && n < budget);
        check("wait COUNT reached", int'(COUNT), target);
    endtask

    int n;
    logic [3:0] rr [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        CLEAR = 1'b0; ENABLE = 1'b0; LOAD = 1'b0; DIV_IN = '0; REQ = '0;
        repeat (2) @(posedge CLOCK);
        check("reset COUNT", int'(COUNT), 0);
        check("reset TICK", int'(TICK), 0);
        check("reset GNT", int'(GNT), 0);
        check("reset GNT_ID", int'(GNT_ID), 0);
        check("reset BUSY", int'(BUSY), 0);
        #1 CLEAR = 1'b1; ENABLE = 1'b1; chk_en = 1'b1;

        // Default divide 14: RUN entry edge, then 15 edges to the first TICK.
        wait_tick(40, n); check("first tick latency", n, 16);
        check("tick without req GNT", int'(GNT), 0);
        wait_tick(40, n); check("default period 1", n, 15);
        wait_tick(40, n); check("default period 2", n, 15);

        // Mid-period reload to 3.
        wait_count(9, 20);
        #1 LOAD = 1'b1; DIV_IN = 4'd3;
        @(posedge CLOCK);
        check("load BUSY", int'(BUSY), 1);
        check("load COUNT", int'(COUNT), 0);
        #1 LOAD = 1'b0;
        wait_tick(20, n); check("reload first tick", n, 5);
        wait_tick(20, n); check("div3 period 1", n, 4);
        wait_tick(20, n); check("div3 period 2", n, 4);

        // Full round robin.
        #1 REQ = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_tick(20, n);
            check("rr period", n, 4);
            check("rr GNT", int'(GNT), int'(rr[k % 4]));
            check("rr GNT_ID", int'(GNT_ID), k % 4);
        end
        wait_tick(20, n); check("rr wrap GNT", int'(GNT), 1);
        #1 REQ = 4'b0101;
        wait_tick(20, n); check("sparse GNT a", int'(GNT), 4);
        check("sparse GNT_ID a", int'(GNT_ID), 2);
        wait_tick(20, n); check("sparse GNT b", int'(GNT), 1);
        check("sparse GNT_ID b", int'(GNT_ID), 0);
        #1 REQ = 4'b0000;
        wait_tick(20, n); check("idle tick TICK", int'(TICK), 1);
        check("idle tick GNT", int'(GNT), 0);
        check("idle tick GNT_ID", int'(GNT_ID), 0);

        // Pause at COUNT=3 with divide 5.
        #1 LOAD = 1'b1; DIV_IN = 4'd5;
        @(posedge CLOCK);
        #1 LOAD = 1'b0;
        wait_count(3, 20);
        #1 ENABLE = 1'b0;
        repeat (10) begin
            @(posedge CLOCK);
            check("paused COUNT", int'(COUNT), 3);
        end
        #1 ENABLE = 1'b1;
        wait_tick(20, n); check("resume tick latency", n, 4);

        // Async clear while a grant is showing (PTR is 1 here).
        #1 REQ = 4'b1111;
        wait_tick(20, n); check("pre-clear period", n, 6);
        check("pre-clear GNT", int'(GNT), 2);
        #2 CLEAR = 1'b0;
        #1;
        check("clear TICK", int'(TICK), 0);
        check("clear GNT", int'(GNT), 0);
        check("clear GNT_ID", int'(GNT_ID), 0);
        check("clear COUNT", int'(COUNT), 0);
        check("clear BUSY", int'(BUSY), 0);
        #1 CLEAR = 1'b1;
        wait_tick(40, n); check("post-clear default div", n, 16);
        check("post-clear PTR reset", int'(GNT), 1);

        // Divide 0: TICK every cycle.
        #1 LOAD = 1'b1; DIV_IN = 4'd0;
        @(posedge CLOCK);
        #1 LOAD = 1'b0;
        wait_tick(10, n); check("div0 first tick", n, 2);
        wait_tick(10, n); check("div0 period 1", n, 1);
        wait_tick(10, n); check("div0 period 2", n, 1);
        @(posedge CLOCK);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
